// File: rtl/soe_to_par_10_hrx2_if.sv
// Half-vector beat bus into the 10-element vector assembler and its assembled-vector output.
interface soe_to_par_10_hrx2_if #(parameter int IN_WIDTH = 10);
  logic                       enable, inReady, inSeries, inStall, expectSeries;
  logic signed [IN_WIDTH-1:0] I0, I1, I2, I3, I4;
  logic signed [IN_WIDTH-1:0] O0, O1, O2, O3, O4, O5, O6, O7, O8, O9;
  logic                       outValid, outTaken, seqError, clearErr;
  logic [7:0]                 dropCount;

  modport slave (
    input  enable, inReady, inSeries, I0, I1, I2, I3, I4, outTaken, clearErr,
    output inStall, expectSeries, O0, O1, O2, O3, O4, O5, O6, O7, O8, O9,
           outValid, seqError, dropCount
  );

  modport master (
    output enable, inReady, inSeries, I0, I1, I2, I3, I4, outTaken, clearErr,
    input  inStall, expectSeries, O0, O1, O2, O3, O4, O5, O6, O7, O8, O9,
           outValid, seqError, dropCount
  );
endinterface

// File: rtl/soe_to_par_10_hrx2.sv
// Assembles tagged lo/hi half-vector beats into one 10-element vector with
// tag-error detection, saturating drop counting and downstream backpressure.
module soe_to_par_10_hrx2 #(parameter int IN_WIDTH = 10) (
  input logic                clk,
  input logic                reset,
  soe_to_par_10_hrx2_if.slave bus
);
  localparam logic [0:0] EXPECT_LO = 1'b0;
  localparam logic [0:0] EXPECT_HI = 1'b1;

  logic [0:0]                   phase;
  logic [4:0][IN_WIDTH-1:0]     loBuf;
  logic [9:0][IN_WIDTH-1:0]     outVec;
  logic [4:0][IN_WIDTH-1:0]     inVec;
  logic                         outValid, seqError;
  logic [7:0]                   dropCount;
  logic                         stall, accept, complete, drop;

  assign inVec = {bus.I4, bus.I3, bus.I2, bus.I1, bus.I0};

  // Only a hi beat can overwrite O; lo beats may proceed under backpressure.
  assign stall    = (phase == EXPECT_HI) & outValid & ~bus.outTaken;
  assign accept   = bus.enable & bus.inReady & ~stall;
  assign complete = accept & (phase == EXPECT_HI) & bus.inSeries;
  assign drop     = accept & ((phase == EXPECT_LO) == bus.inSeries);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= EXPECT_LO;
      loBuf     <= '0;
      outVec    <= '0;
      outValid  <= 1'b0;
      seqError  <= 1'b0;
      dropCount <= 8'd0;
    end else begin
      if (bus.outTaken & outValid) outValid <= 1'b0;
      if (bus.clearErr) begin
        seqError  <= 1'b0;
        dropCount <= 8'd0;
      end
      if (accept) begin
        if (phase == EXPECT_LO) begin
          if (!bus.inSeries) begin
            loBuf <= inVec;
            phase <= EXPECT_HI;
          end
        end else if (bus.inSeries) begin
          outVec   <= {inVec, loBuf};
          outValid <= 1'b1;
          phase    <= EXPECT_LO;
        end else begin
          loBuf <= inVec;
        end
      end
      // A discard in the same cycle as clearErr restarts the count at one.
      if (drop) begin
        seqError <= 1'b1;
        if (bus.clearErr)           dropCount <= 8'd1;
        else if (dropCount != 8'hff) dropCount <= dropCount + 8'd1;
      end
    end
  end

  assign bus.inStall      = stall;
  assign bus.expectSeries = phase[0];
  assign bus.outValid     = outValid;
  assign bus.seqError     = seqError;
  assign bus.dropCount    = dropCount;
  assign bus.O0 = outVec[0];
  assign bus.O1 = outVec[1];
  assign bus.O2 = outVec[2];
  assign bus.O3 = outVec[3];
  assign bus.O4 = outVec[4];
  assign bus.O5 = outVec[5];
  assign bus.O6 = outVec[6];
  assign bus.O7 = outVec[7];
  assign bus.O8 = outVec[8];
  assign bus.O9 = outVec[9];

  logic unusedComplete;
  assign unusedComplete = complete;
endmodule

// File: doc/soe_to_par_10_hrx2.md
SOE_TO_PAR_10_HRX2 -- requirements
Module: soe_to_par_10_hrx2

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 10, which sets the element width in bits for inputs and outputs.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: when low, input beats are not accepted.
REQ-005 The block SHALL have port inReady, input, 1 bit: a half-vector beat is present on I0..I4 this cycle.
REQ-006 The block SHALL have port inSeries, input, 1 bit: beat tag; 0 = elements 0-4, 1 = elements 5-9.
REQ-007 The block SHALL have ports I0..I4, input, signed IN_WIDTH each: half-vector elements.
REQ-008 The block SHALL have port inStall, output, 1 bit, combinational: upstream must hold the current beat.
REQ-009 The block SHALL have port expectSeries, output, 1 bit: current FSM phase (0 = EXPECT_LO, 1 = EXPECT_HI).
REQ-010 The block SHALL have ports O0..O9, output reg, signed IN_WIDTH each: the assembled 10-element vector.
REQ-011 The block SHALL have port outValid, output reg, 1 bit: O0..O9 hold an unconsumed vector.
REQ-012 The block SHALL have port outTaken, input, 1 bit: downstream consumes the vector while outValid=1.
REQ-013 The block SHALL have port seqError, output reg, 1 bit: sticky flag set on any inSeries/phase mismatch.
REQ-014 The block SHALL have port dropCount, output reg, 8 bits: saturating count of discarded beats.
REQ-015 The block SHALL have port clearErr, input, 1 bit: clears seqError and dropCount.

Function
REQ-016 The block SHALL define an accepted beat as: enable & inReady & ~inStall.
REQ-017 The block SHALL drive inStall = (phase==EXPECT_HI) & outValid & ~outTaken, regardless of the inSeries value.
REQ-018 In EXPECT_LO, an accepted beat with inSeries=0 SHALL latch I0..I4 into an internal lo buffer and move the FSM to EXPECT_HI.
REQ-019 In EXPECT_LO, an accepted beat with inSeries=1 SHALL be discarded: seqError<=1, dropCount increments, and the FSM stays in EXPECT_LO.
REQ-020 In EXPECT_HI, an accepted beat with inSeries=1 SHALL:
- load O0..O4 from the lo buffer;
- load O5..O9 from I0..I4;
- set outValid<=1;
- move the FSM to EXPECT_LO.
REQ-021 In EXPECT_HI, an accepted beat with inSeries=0 SHALL:
- discard the buffered half and overwrite the lo buffer with I0..I4;
- set seqError<=1;
- increment dropCount;
- keep the FSM in EXPECT_HI.
REQ-022 Latency SHALL be 1 cycle: a completing beat at edge N gives outValid=1 and valid O0..O9 after edge N.
REQ-023 outTaken & outValid SHALL clear outValid at the next edge, unless a completing beat is accepted in the same cycle; in that case outValid stays 1 and O0..O9 take the new vector.
REQ-024 outTaken while outValid=0 SHALL have no effect.
REQ-025 outTaken SHALL be honoured regardless of enable.
REQ-026 O0..O9 SHALL change only on a completing beat; otherwise they hold their value while outValid=0.
REQ-027 A non-accepted beat (enable=0, inReady=0 or inStall=1) SHALL cause no change to the FSM, buffers, seqError or dropCount.
REQ-028 dropCount SHALL saturate at 255 and never wrap.
REQ-029 clearErr SHALL set seqError<=0 and dropCount<=0; if a discard occurs in the same cycle, the result SHALL be seqError=1 and dropCount=1.
REQ-030 Elements SHALL be passed bit-exact; no arithmetic, sign extension or truncation is permitted.

Reset
REQ-031 On reset the FSM SHALL enter EXPECT_LO (expectSeries=0).
REQ-032 On reset the block SHALL clear outValid, O0..O9, the lo buffer, seqError and dropCount to 0.
REQ-033 Reset SHALL take priority over every other input, including an accepted beat or outTaken in the same cycle.
REQ-034 Reset asserted mid-vector (EXPECT_HI) SHALL discard the buffered half without counting it as a drop.

Verification
REQ-035 The bench SHALL cover a basic pair: beat inSeries=0 with I=1,2,3,4,5, then inSeries=1 with I=6,7,8,9,10, outTaken=1 -> O0..O9=1..10, outValid one cycle high, seqError=0.
REQ-036 The bench SHALL cover backpressure: outValid=1, outTaken=0, new lo beat then hi beat -> lo beat is accepted, inStall=1 on the hi beat, O unchanged; outTaken=1 -> hi beat accepted the same cycle, outValid stays 1 with the new vector.
REQ-037 The bench SHALL cover a tag error: in EXPECT_LO, beat inSeries=1 -> seqError=1, dropCount=1, expectSeries=0; then a correct pair of -5s -> O0..O9 all -5.
REQ-038 The bench SHALL cover a resync: lo beat A, lo beat B, hi beat C -> O0..O4=B, O5..O9=C, dropCount=1.
REQ-039 The bench SHALL cover saturation and clear: 300 tag errors -> dropCount=255; then clearErr together with an error beat -> dropCount=1, seqError=1.
REQ-040 The bench SHALL cover reset mid-vector: lo beat, then reset, then hi beat -> beat discarded as an error (dropCount=1), outValid=0, O0..O9=0.
